// File: rtl/mult_arbiter.sv
// Two-requester front end for one shared 16x16 unsigned multiplier.
// Round-robin grant, one transaction in flight, response held until accepted.

module Mult16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out1,
  output logic [15:0] out2
);

  logic [31:0] w_full;

  assign w_full = {16'd0, a} * {16'd0, b};
  assign out1   = w_full[15:0];
  assign out2   = w_full[31:16];

endmodule

module mult_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_prod,
  output logic        rsp_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t      r_state;
  logic        r_ptr;
  logic [15:0] r_opA;
  logic [15:0] r_opB;
  logic        r_rspId;
  logic [31:0] r_rspProd;
  logic        r_rspOvf;

  logic [15:0] w_out1;
  logic [15:0] w_out2;
  logic [1:0]  w_grant;
  logic        w_hs;
  logic        w_grantId;

  Mult16 uMult (
    .a    (r_opA),
    .b    (r_opB),
    .out1 (w_out1),
    .out2 (w_out2)
  );

  // Grant is only offered in IDLE; on contention the pointer's requester wins.
  always_comb begin
    w_grant = 2'b00;
    if (!rst && r_state == IDLE) begin
      case (req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11:   w_grant = r_ptr ? 2'b10 : 2'b01;
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_hs      = |(req_valid & w_grant);
  assign w_grantId = w_grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= 1'b0;
      r_opA     <= 16'd0;
      r_opB     <= 16'd0;
      r_rspId   <= 1'b0;
      r_rspProd <= 32'd0;
      r_rspOvf  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_opA   <= w_grantId ? req1_a : req0_a;
            r_opB   <= w_grantId ? req1_b : req0_b;
            r_rspId <= w_grantId;
            r_ptr   <= ~w_grantId;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_rspProd <= {w_out2, w_out1};
          r_rspOvf  <= (w_out2 != 16'd0);
          r_state   <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = w_grant;
  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_rspId;
  assign rsp_prod  = r_rspProd;
  assign rsp_ovf   = r_rspOvf;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: expected responses are queued at each
// accepted request and compared when the response appears.

module tb_mult_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_prod;
  logic        rsp_ovf;
  logic        busy;

  typedef struct {
    logic        id;
    logic [31:0] prod;
    logic        ovf;
  } exp_t;

  exp_t sbq[$];
  logic modelPtr;
  int   checks;
  int   fails;

  mult_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference arbitration: sole requester wins, otherwise the pointer decides.
  function automatic logic [1:0] modelGrant(input logic [1:0] v);
    case (v)
      2'b01:   return 2'b01;
      2'b10:   return 2'b10;
      2'b11:   return modelPtr ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // Queue the expected response for a grant and advance the reference pointer.
  task automatic pushExpected(input logic [1:0] grant);
    exp_t e;
    logic [31:0] pa, pb;
    if (grant != 2'b00) begin
      e.id = grant[1];
      pa   = e.id ? {16'd0, req1_a} : {16'd0, req0_a};
      pb   = e.id ? {16'd0, req1_b} : {16'd0, req0_b};
      e.prod = pa * pb;
      e.ovf  = (e.prod[31:16] != 16'd0);
      sbq.push_back(e);
      modelPtr = ~e.id;
    end
  endtask

  task automatic popExpected(output exp_t e, output logic ok);
    ok = (sbq.size() != 0);
    if (ok) e = sbq.pop_front();
    else begin
      e.id = 1'b0; e.prod = 32'd0; e.ovf = 1'b0;
    end
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    modelPtr = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    req0_a = 16'h1111; req0_b = 16'h2222; req1_a = 16'h3333; req1_b = 16'h4444;
    @(negedge clk);
    checks++; if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL reset_req_ready got=%b want=00", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    checks++; if (rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_id got=%b want=0", rsp_id); end
    checks++; if (rsp_prod !== 32'd0) begin fails++; $display("[TB] FAIL reset_rsp_prod got=%h want=0", rsp_prod); end
    checks++; if (rsp_ovf !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_ovf got=%b want=0", rsp_ovf); end
    checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    req_valid = 2'b00;
    rst = 1'b0;
    modelPtr = 1'b0;
    sbq.delete();
    @(negedge clk);
  endtask

  task automatic test_single();
    logic [1:0] g;
    exp_t e;
    logic ok;
    req0_a = 16'h0007; req0_b = 16'h0007; req_valid = 2'b01;
    #1;
    g = modelGrant(req_valid);
    checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL single_grant got=%b want=%b", req_ready, g); end
    pushExpected(g);
    @(negedge clk);
    req_valid = 2'b00;
    checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_calc_valid got=%b want=0", rsp_valid); end
    checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL single_calc_busy got=%b want=1", busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL single_latency got=%b want=1", rsp_valid); end
    popExpected(e, ok);
    checks++; if (!ok || rsp_prod !== e.prod) begin fails++; $display("[TB] FAIL single_prod got=%h want=%h", rsp_prod, e.prod); end
    checks++; if (rsp_ovf !== e.ovf) begin fails++; $display("[TB] FAIL single_ovf got=%b want=%b", rsp_ovf, e.ovf); end
    checks++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL single_id got=%b want=%b", rsp_id, e.id); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL single_idle busy=%b valid=%b want 0/0", busy, rsp_valid); end
  endtask

  // Both requesters held valid for several transactions: grants must alternate.
  task automatic test_round_robin(input int n, input string tag);
    logic [1:0] g;
    exp_t e;
    logic ok;
    for (int t = 0; t < n; t++) begin
      req_valid = 2'b11;
      #1;
      g = modelGrant(req_valid);
      checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL %s_grant%0d got=%b want=%b", tag, t, req_ready, g); end
      pushExpected(g);
      @(negedge clk);
      checks++; if (req_ready !== 2'b00) begin fails++; $display("[TB] FAIL %s_calc_ready%0d got=%b want=00", tag, t, req_ready); end
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL %s_valid%0d got=%b want=1", tag, t, rsp_valid); end
      popExpected(e, ok);
      checks++; if (!ok || rsp_id !== e.id) begin fails++; $display("[TB] FAIL %s_id%0d got=%b want=%b", tag, t, rsp_id, e.id); end
      checks++; if (rsp_prod !== e.prod) begin fails++; $display("[TB] FAIL %s_prod%0d got=%h want=%h", tag, t, rsp_prod, e.prod); end
      checks++; if (rsp_ovf !== e.ovf) begin fails++; $display("[TB] FAIL %s_ovf%0d got=%b want=%b", tag, t, rsp_ovf, e.ovf); end
      @(negedge clk);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_rr_from_reset();
    pulseReset();
    req0_a = 16'd3; req0_b = 16'd5; req1_a = 16'h0100; req1_b = 16'h0100;
    test_round_robin(5, "rr");
  endtask

  task automatic test_backpressure();
    logic [1:0] g;
    exp_t e;
    logic ok;
    rsp_ready = 1'b0;
    req1_a = 16'hFFFF; req1_b = 16'hFFFF; req_valid = 2'b10;
    #1;
    g = modelGrant(req_valid);
    checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL bp_grant got=%b want=%b", req_ready, g); end
    pushExpected(g);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    popExpected(e, ok);
    checks++; if (!ok) begin fails++; $display("[TB] FAIL bp_scoreboard got=empty want=entry"); end
    req_valid = 2'b01;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL bp_valid%0d got=%b want=1", c, rsp_valid); end
      checks++; if (rsp_prod !== e.prod || rsp_ovf !== e.ovf) begin fails++; $display("[TB] FAIL bp_data%0d got=%h/%b want=%h/%b", c, rsp_prod, rsp_ovf, e.prod, e.ovf); end
      checks++; if (rsp_id !== e.id) begin fails++; $display("[TB] FAIL bp_id%0d got=%b want=%b", c, rsp_id, e.id); end
      checks++; if (busy !== 1'b1 || req_ready !== 2'b00) begin fails++; $display("[TB] FAIL bp_hold%0d busy=%b ready=%b want 1/00", c, busy, req_ready); end
      @(negedge clk);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL bp_release busy=%b valid=%b want 0/0", busy, rsp_valid); end
  endtask

  task automatic test_reset_abort();
    logic [1:0] g;
    exp_t e;
    logic ok;
    req0_a = 16'd9; req0_b = 16'd9; req_valid = 2'b01;
    #1;
    g = modelGrant(req_valid);
    checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL abort_grant got=%b want=%b", req_ready, g); end
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 2'b00) begin fails++; $display("[TB] FAIL abort_ctrl valid=%b busy=%b ready=%b want 0/0/00", rsp_valid, busy, req_ready); end
    checks++; if (rsp_prod !== 32'd0 || rsp_ovf !== 1'b0 || rsp_id !== 1'b0) begin fails++; $display("[TB] FAIL abort_data prod=%h ovf=%b id=%b want 0/0/0", rsp_prod, rsp_ovf, rsp_id); end
    @(negedge clk);
    rst = 1'b0;
    modelPtr = 1'b0;
    sbq.delete();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_novalid%0d got=%b want=0", c, rsp_valid); end
    end
    req_valid = 2'b11;
    #1;
    g = modelGrant(req_valid);
    checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL abort_ptr got=%b want=%b", req_ready, g); end
    req1_a = 16'd2; req1_b = 16'd2; req_valid = 2'b10;
    #1;
    g = modelGrant(req_valid);
    checks++; if (req_ready !== g) begin fails++; $display("[TB] FAIL abort_req1_grant got=%b want=%b", req_ready, g); end
    pushExpected(g);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1) begin fails++; $display("[TB] FAIL abort_req1_valid got=%b want=1", rsp_valid); end
    popExpected(e, ok);
    checks++; if (!ok || rsp_prod !== e.prod || rsp_id !== e.id) begin fails++; $display("[TB] FAIL abort_req1_rsp got=%h/%b want=%h/%b", rsp_prod, rsp_id, e.prod, e.id); end
    @(negedge clk);
  endtask

  task automatic test_zero_operand();
    req0_a = 16'h0000; req0_b = 16'h1234; req1_a = 16'd3; req1_b = 16'd4;
    test_round_robin(2, "zero");
  endtask

  initial begin
    checks = 0;
    fails = 0;
    modelPtr = 1'b0;
    rst = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
    test_reset();
    test_single();
    test_rr_from_reset();
    test_backpressure();
    test_reset_abort();
    test_zero_operand();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
